// File: rtl/left_shifter_seq.sv
// Multi-cycle barrel shifter: five log2 stages, one per clock.
// Optional rotate mode is compiled in with LEFT_SHIFTER_SEQ_ROTATE_EN.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, sampled only while idle
//   in    - 32-bit operand, captured on accepted start
//   sha   - 5-bit shift amount, captured on accepted start
//   rot   - rotate select (only with LEFT_SHIFTER_SEQ_ROTATE_EN)
//   busy  - high while a shift is in progress
//   done  - one-cycle pulse when out holds a new result
//   out   - registered result, held until the next completion
module left_shifter_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [4:0]  sha,
`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
  input  logic        rot,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  k;
  logic [31:0] acc;
  logic [4:0]  amt;
  logic [4:0]  s;
  logic [31:0] nxt;

`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
  logic        rot_q;
`endif

  assign busy = (state == SHIFT);

  // Stage k moves by 2^k when the matching amount bit is set.
  always_comb begin
    s   = 5'd1 << k;
    nxt = acc;
    if (amt[k]) begin
`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
      if (rot_q)
        nxt = (acc << s) |
              (acc >> (6'd32 - {1'b0, s}));
      else
        nxt = acc << s;
`else
      nxt = acc << s;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= 3'd0;
      acc   <= 32'd0;
      amt   <= 5'd0;
      done  <= 1'b0;
      out   <= 32'd0;
`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
      rot_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= in;
            amt   <= sha;
            k     <= 3'd0;
            state <= SHIFT;
`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
            rot_q <= rot;
`endif
          end
        end
        SHIFT: begin
          acc <= nxt;
          k   <= k + 3'd1;
          if (k == 3'd4) begin
            out   <= nxt;
            done  <= 1'b1;
            k     <= 3'd0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_left_shifter_seq.sv
// Directed plus randomized bench for left_shifter_seq.
// Reference result comes from plain shift / bit-rotate arithmetic.
module tb_left_shifter_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] in;
  logic [4:0]  sha;
  logic        rot;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int checks   = 0;
  int failures = 0;

  left_shifter_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .sha   (sha),
`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
    .rot   (rot),
`endif
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [31:0] x,
    input int          n,
    input logic        r
  );
    logic [31:0] v;
    v = x;
`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
    if (r) begin
      for (int i = 0; i < n; i++)
        v = {v[30:0], v[31]};
      return v;
    end
`endif
    return x << n;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and clocks the accept edge.
  task automatic launch(
    input logic [31:0] a,
    input logic [4:0]  n,
    input logic        r
  );
    start = 1'b1;
    in    = a;
    sha   = n;
    rot   = r;
    tick();
    start = 1'b0;
  endtask

  // Runs the five shift edges; optionally hammers start with junk.
  task automatic finish(
    input string       tag,
    input logic [31:0] exp,
    input logic [31:0] prev,
    input bit          noise
  );
    for (int i = 0; i < 5; i++) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " nodone"}, {31'd0, done}, 32'd0);
      chk({tag, " hold"}, out, prev);
      if (noise) begin
        start = 1'b1;
        in    = $urandom;
        sha   = 5'($urandom);
        rot   = 1'($urandom);
      end
      tick();
    end
    start = 1'b0;
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
    chk({tag, " out"}, out, exp);
  endtask

  // One cycle after done: pulse gone, result held, nothing queued.
  task automatic settle(input string tag, input logic [31:0] exp);
    tick();
    chk({tag, " pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " noq"}, {31'd0, busy}, 32'd0);
    chk({tag, " keep"}, out, exp);
  endtask

  logic [31:0] cur;
  logic [31:0] e;
  logic [31:0] a;
  logic [4:0]  n;
  logic        r;
  int          seen;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    in    = 32'd0;
    sha   = 5'd0;
    rot   = 1'b0;
    #2;
    chk("rst out", out, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    start = 1'b1;
    tick();
    tick();
    chk("rst ign", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    cur   = 32'd0;

    launch(32'h0000_0001, 5'd31, 1'b0);
    finish("d31", 32'h8000_0000, cur, 1'b0);
    cur = 32'h8000_0000;
    settle("d31", cur);

    launch(32'hDEAD_BEEF, 5'd0, 1'b0);
    finish("d0", 32'hDEAD_BEEF, cur, 1'b0);
    cur = 32'hDEAD_BEEF;
    settle("d0", cur);

    launch(32'h1234_5678, 5'd12, 1'b0);
    finish("drop", 32'h4567_8000, cur, 1'b1);
    cur = 32'h4567_8000;
    settle("drop", cur);

    launch(32'h0000_00FF, 5'd4, 1'b0);
    finish("b2b1", 32'h0000_0FF0, cur, 1'b0);
    cur = 32'h0000_0FF0;
    launch(32'h0000_0003, 5'd30, 1'b0);
    chk("b2b pulse", {31'd0, done}, 32'd0);
    finish("b2b2", 32'hC000_0000, cur, 1'b0);
    cur = 32'hC000_0000;
    settle("b2b2", cur);

`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
    launch(32'h8000_0001, 5'd4, 1'b1);
    finish("rot1", 32'h0000_0018, cur, 1'b0);
    cur = 32'h0000_0018;
    settle("rot1", cur);
    launch(32'h8000_0001, 5'd4, 1'b0);
    finish("rot0", 32'h0000_0010, cur, 1'b0);
    cur = 32'h0000_0010;
    settle("rot0", cur);
`endif

    for (int t = 0; t < 24; t++) begin
      a = $urandom;
      n = 5'($urandom);
`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
      r = 1'($urandom);
`else
      r = 1'b0;
`endif
      e = model(a, int'(n), r);
      launch(a, n, r);
      finish($sformatf("rnd%0d", t), e, cur, t[0]);
      cur = e;
      settle($sformatf("rnd%0d", t), cur);
    end

    launch(32'hFFFF_FFFF, 5'd8, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("abort out", out, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) seen++;
    end
    chk("abort nodone", seen, 0);
    chk("abort idle", {31'd0, busy}, 32'd0);
    chk("abort out2", out, 32'd0);

    launch(32'h0000_0005, 5'd1, 1'b0);
    finish("post", 32'h0000_000A, 32'd0, 1'b0);
    settle("post", 32'h0000_000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
